// File: rtl/spi_frame_shifter_pkg.sv
// Shared types and constants for the SPI frame shifter slice.
package spi_frame_shifter_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_e;

  localparam int unsigned DEFAULT_WIDTH = 8;

  // Bit shifted out when no transmit word is waiting in the holding register.
  localparam logic IDLE_FILL_BIT = 1'b1;

endpackage

// File: rtl/spi_frame_shifter_bit_counter.sv
// spi_bit_counter: bit position within the current frame word, wrapping at WIDTH.
module spi_bit_counter
  import spi_frame_shifter_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          clr_i,
  input  logic          inc_i,
  output logic [CW-1:0] count_o,
  output logic          boundary_o,
  output logic          last_o
);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // Counter register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= {CW{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  // Next count: clear while deselected, wrap after the last bit of a word.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = {CW{1'b0}};
    end else if (inc_i) begin
      if (last_o) begin
        count_d = {CW{1'b0}};
      end else begin
        count_d = count_q + {{(CW-1){1'b0}}, 1'b1};
      end
    end else begin
      count_d = count_q;
    end
  end

  assign count_o    = count_q;
  assign boundary_o = (count_q == {CW{1'b0}});
  assign last_o     = (count_q == CW'(WIDTH - 1));

endmodule

// File: rtl/spi_frame_shifter.sv
// SPI peripheral framing stage: MSB-first receive words and buffered transmit words.
// Optional feature: define SPI_FRAME_OVERRUN_EN to add the sticky rx_overrun output.
module spi_frame_shifter
  import spi_frame_shifter_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             sclk_posedge,
  input  logic             sclk_negedge,
  input  logic             cs_n,
  input  logic             mosi,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  input  logic             rx_ack,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_load,
  output logic             tx_ready,
  output logic             miso,
  output logic             miso_oe
`ifdef SPI_FRAME_OVERRUN_EN
  ,
  output logic             rx_overrun
`endif
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  rx_shift_q, rx_shift_d;
  logic [WIDTH-1:0]  rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic [WIDTH-1:0]  tx_shift_q, tx_shift_d;
  logic [WIDTH-1:0]  hold_q, hold_d;
  logic              tx_ready_q, tx_ready_d;
  logic              miso_q, miso_d;
  logic              miso_oe_q, miso_oe_d;

  logic              enter_s;
  logic              active_s;
  logic              pos_s;
  logic              neg_s;
  logic              word_done_s;
  logic              tx_xfer_s;
  logic [WIDTH-1:0]  next_word_s;
  logic [WIDTH-1:0]  rx_word_s;
  logic [CW-1:0]     count_s;
  logic              boundary_s;
  logic              last_s;

  // A deselect in the same cycle as an SCLK edge suppresses that edge.
  assign enter_s     = (state_q == IDLE) && !cs_n;
  assign active_s    = (state_q == ACTIVE) && !cs_n;
  assign pos_s       = active_s && sclk_posedge;
  assign neg_s       = active_s && sclk_negedge;
  assign word_done_s = pos_s && last_s;
  assign tx_xfer_s   = enter_s || (neg_s && boundary_s);
  assign next_word_s = tx_ready_q ? {WIDTH{IDLE_FILL_BIT}} : hold_q;
  assign rx_word_s   = {rx_shift_q[WIDTH-2:0], mosi};

  spi_bit_counter #(.WIDTH(WIDTH)) u_bit_counter (
    .clk        (clk),
    .reset_n    (reset_n),
    .clr_i      (!active_s),
    .inc_i      (pos_s),
    .count_o    (count_s),
    .boundary_o (boundary_s),
    .last_o     (last_s)
  );

  // Frame state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Frame state transitions follow chip select.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = cs_n ? IDLE : ACTIVE;
      ACTIVE:  state_d = cs_n ? IDLE : ACTIVE;
      default: state_d = IDLE;
    endcase
  end

  // Receive path: shift on SCLK rising edges, publish each completed word.
  always_comb begin
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    if (enter_s) begin
      rx_shift_d = {WIDTH{1'b0}};
    end else if (pos_s) begin
      rx_shift_d = rx_word_s;
    end else begin
      rx_shift_d = rx_shift_q;
    end
    if (word_done_s) begin
      rx_data_d  = rx_word_s;
      rx_valid_d = 1'b1;
    end else if (rx_ack) begin
      rx_valid_d = 1'b0;
    end else begin
      rx_valid_d = rx_valid_q;
    end
  end

  // Transmit path: holding register handshake, shifter reload at word boundaries.
  always_comb begin
    tx_shift_d = tx_shift_q;
    hold_d     = hold_q;
    tx_ready_d = tx_ready_q;
    if (tx_xfer_s) begin
      tx_shift_d = next_word_s;
      tx_ready_d = 1'b1;
    end else if (neg_s) begin
      tx_shift_d = {tx_shift_q[WIDTH-2:0], 1'b0};
    end else begin
      tx_shift_d = tx_shift_q;
    end
    if (tx_load && tx_ready_q) begin
      hold_d     = tx_data;
      tx_ready_d = 1'b0;
    end else begin
      hold_d = hold_q;
    end
  end

  // MISO level and its output enable.
  always_comb begin
    miso_d    = miso_q;
    miso_oe_d = !cs_n;
    if (enter_s) begin
      miso_d = next_word_s[WIDTH-1];
    end else if (!active_s) begin
      miso_d = 1'b0;
    end else if (neg_s) begin
      miso_d = tx_shift_d[WIDTH-1];
    end else begin
      miso_d = miso_q;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_shift_q <= {WIDTH{1'b0}};
      rx_data_q  <= {WIDTH{1'b0}};
      rx_valid_q <= 1'b0;
      tx_shift_q <= {WIDTH{1'b0}};
      hold_q     <= {WIDTH{1'b0}};
      tx_ready_q <= 1'b1;
      miso_q     <= 1'b0;
      miso_oe_q  <= 1'b0;
    end else begin
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      tx_shift_q <= tx_shift_d;
      hold_q     <= hold_d;
      tx_ready_q <= tx_ready_d;
      miso_q     <= miso_d;
      miso_oe_q  <= miso_oe_d;
    end
  end

  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign tx_ready = tx_ready_q;
  assign miso     = miso_q;
  assign miso_oe  = miso_oe_q;

`ifdef SPI_FRAME_OVERRUN_EN
  logic ovr_q, ovr_d;

  // Sticky overrun: a word lands on top of one nobody has taken.
  always_comb begin
    ovr_d = ovr_q;
    if (word_done_s && rx_valid_q && !rx_ack) begin
      ovr_d = 1'b1;
    end else if (rx_ack) begin
      ovr_d = 1'b0;
    end else begin
      ovr_d = ovr_q;
    end
  end

  // Overrun flag register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovr_q <= 1'b0;
    end else begin
      ovr_q <= ovr_d;
    end
  end

  assign rx_overrun = ovr_q;
`endif

endmodule

// File: tb/tb_spi_frame_shifter.sv
// Directed, table-driven bench for spi_frame_shifter (WIDTH = 8).
module tb_spi_frame_shifter;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       sclk_posedge, sclk_negedge, cs_n, mosi;
  logic [7:0] rx_data;
  logic       rx_valid, rx_ack;
  logic [7:0] tx_data;
  logic       tx_load, tx_ready, miso, miso_oe;
`ifdef SPI_FRAME_OVERRUN_EN
  logic       rx_overrun;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  spi_frame_shifter #(.WIDTH(8)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .sclk_posedge (sclk_posedge),
    .sclk_negedge (sclk_negedge),
    .cs_n         (cs_n),
    .mosi         (mosi),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ack       (rx_ack),
    .tx_data      (tx_data),
    .tx_load      (tx_load),
    .tx_ready     (tx_ready),
    .miso         (miso),
    .miso_oe      (miso_oe)
`ifdef SPI_FRAME_OVERRUN_EN
    ,
    .rx_overrun   (rx_overrun)
`endif
  );

  typedef struct {
    logic [7:0] mosi_w;
    logic [7:0] tx_w;
    logic       load;
    logic [7:0] exp_rx;
    logic [7:0] exp_miso;
  } vec_t;

  vec_t vecs[4];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Shift n bits MSB-first; records the MISO level presented before each rising edge.
  task automatic send_bits(input logic [7:0] w, input int n, input logic ack_last,
                           output logic [7:0] seen);
    seen = 8'h00;
    for (int i = 0; i < n; i++) begin
      seen[7-i]    = miso;
      mosi         = w[7-i];
      sclk_posedge = 1'b1;
      rx_ack       = ack_last && (i == n - 1);
      tick();
      sclk_posedge = 1'b0;
      rx_ack       = 1'b0;
      tick();
      sclk_negedge = 1'b1;
      tick();
      sclk_negedge = 1'b0;
      tick();
    end
  endtask

  task automatic frame(input logic [7:0] w, input logic ack_last, output logic [7:0] seen);
    cs_n = 1'b0;
    tick();
    send_bits(w, 8, ack_last, seen);
    cs_n = 1'b1;
    tick();
  endtask

  task automatic load_word(input logic [7:0] w);
    tx_data = w;
    tx_load = 1'b1;
    tick();
    tx_load = 1'b0;
  endtask

  task automatic ack();
    rx_ack = 1'b1;
    tick();
    rx_ack = 1'b0;
  endtask

  logic [7:0] seen;

  initial begin
    vecs[0] = '{8'hA5, 8'h3C, 1'b1, 8'hA5, 8'h3C};
    vecs[1] = '{8'h5A, 8'h00, 1'b0, 8'h5A, 8'hFF};
    vecs[2] = '{8'hFF, 8'h81, 1'b1, 8'hFF, 8'h81};
    vecs[3] = '{8'h00, 8'hC3, 1'b1, 8'h00, 8'hC3};

    reset_n = 1'b0; cs_n = 1'b1; mosi = 1'b0; sclk_posedge = 1'b0; sclk_negedge = 1'b0;
    rx_ack = 1'b0; tx_load = 1'b0; tx_data = 8'h00;
    tick(); tick();
    reset_n = 1'b1;
    tick();

    chk("reset rx_data", rx_data, 8'h00);
    chk("reset rx_valid", {7'd0, rx_valid}, 8'h00);
    chk("reset tx_ready", {7'd0, tx_ready}, 8'h01);
    chk("reset miso", {7'd0, miso}, 8'h00);
    chk("reset miso_oe", {7'd0, miso_oe}, 8'h00);
`ifdef SPI_FRAME_OVERRUN_EN
    chk("reset rx_overrun", {7'd0, rx_overrun}, 8'h00);
`endif

    // Transmit 0x3C, then a second word with nothing loaded.
    load_word(8'h3C);
    chk("tx_ready after load", {7'd0, tx_ready}, 8'h00);
    cs_n = 1'b0;
    tick();
    chk("tx_ready after transfer", {7'd0, tx_ready}, 8'h01);
    chk("miso_oe after cs low", {7'd0, miso_oe}, 8'h01);
    send_bits(8'h00, 8, 1'b0, seen);
    chk("miso word 0x3C", seen, 8'h3C);
    send_bits(8'h00, 8, 1'b0, seen);
    chk("miso empty fill", seen, 8'hFF);
    cs_n = 1'b1;
    tick();
    chk("miso_oe after cs high", {7'd0, miso_oe}, 8'h00);
    chk("miso idle", {7'd0, miso}, 8'h00);
    ack();

    for (int v = 0; v < 4; v++) begin
      if (vecs[v].load) load_word(vecs[v].tx_w);
      frame(vecs[v].mosi_w, 1'b0, seen);
      chk($sformatf("vec%0d rx_data", v), rx_data, vecs[v].exp_rx);
      chk($sformatf("vec%0d rx_valid", v), {7'd0, rx_valid}, 8'h01);
      chk($sformatf("vec%0d miso", v), seen, vecs[v].exp_miso);
      chk($sformatf("vec%0d tx_ready", v), {7'd0, tx_ready}, 8'h01);
      ack();
      chk($sformatf("vec%0d rx_valid after ack", v), {7'd0, rx_valid}, 8'h00);
    end

    // Abort after 5 bits; a word loaded mid-frame must survive into the next frame.
    cs_n = 1'b0;
    tick();
    load_word(8'h5A);
    send_bits(8'hFF, 5, 1'b0, seen);
    cs_n = 1'b1;
    tick();
    chk("abort rx_valid", {7'd0, rx_valid}, 8'h00);
    chk("abort keeps holding", {7'd0, tx_ready}, 8'h00);

    // Deselect coinciding with the last rising edge: that edge is ignored.
    cs_n = 1'b0;
    tick();
    send_bits(8'hFF, 7, 1'b0, seen);
    chk("held word after abort", {1'b0, seen[7:1]}, 8'h2D);
    cs_n = 1'b1; sclk_posedge = 1'b1; mosi = 1'b1;
    tick();
    sclk_posedge = 1'b0;
    tick();
    chk("cs wins over posedge", {7'd0, rx_valid}, 8'h00);

    frame(8'h81, 1'b0, seen);
    chk("rx after abort", rx_data, 8'h81);
    chk("rx_valid after abort", {7'd0, rx_valid}, 8'h01);
    ack();

    // Two unacknowledged frames.
    frame(8'h12, 1'b0, seen);
    frame(8'h34, 1'b0, seen);
    chk("overwrite rx_data", rx_data, 8'h34);
    chk("overwrite rx_valid", {7'd0, rx_valid}, 8'h01);
`ifdef SPI_FRAME_OVERRUN_EN
    chk("overrun set", {7'd0, rx_overrun}, 8'h01);
`endif
    ack();
`ifdef SPI_FRAME_OVERRUN_EN
    chk("overrun cleared by ack", {7'd0, rx_overrun}, 8'h00);
`endif

    // Acknowledge coincident with the completing edge of the next word.
    frame(8'h12, 1'b0, seen);
    frame(8'h56, 1'b1, seen);
    chk("coincident ack rx_data", rx_data, 8'h56);
    chk("coincident ack rx_valid", {7'd0, rx_valid}, 8'h01);
`ifdef SPI_FRAME_OVERRUN_EN
    chk("coincident ack no overrun", {7'd0, rx_overrun}, 8'h00);
`endif

    // Reset in the middle of a word with a pending word and a loaded holding register.
    cs_n = 1'b0;
    tick();
    load_word(8'h77);
    send_bits(8'hFF, 3, 1'b0, seen);
    reset_n = 1'b0;
    #1;
    chk("midreset rx_data", rx_data, 8'h00);
    chk("midreset rx_valid", {7'd0, rx_valid}, 8'h00);
    chk("midreset tx_ready", {7'd0, tx_ready}, 8'h01);
    chk("midreset miso", {7'd0, miso}, 8'h00);
    chk("midreset miso_oe", {7'd0, miso_oe}, 8'h00);
    cs_n = 1'b1;
    tick();
    reset_n = 1'b1;
    tick();
    frame(8'hA5, 1'b0, seen);
    chk("post-reset rx_data", rx_data, 8'hA5);
    chk("post-reset rx_valid", {7'd0, rx_valid}, 8'h01);
    chk("post-reset miso fill", seen, 8'hFF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/spi_frame_shifter.md
# spi_frame_shifter

Serial-to-parallel and parallel-to-serial framing stage sitting directly downstream of the input conditioners on the SPI peripheral side. It consumes the conditioned MOSI level, the conditioned active-low chip select, and the SCLK positive/negative edge pulses produced by the conditioners. It assembles MSB-first receive words with a valid/ack handshake and serialises a buffered transmit word onto MISO, all in the system clock domain.

## Interface
- WIDTH, 8, bits per frame word (≥2)
- clk  input  1  system clock; all state updates on rising edge
- reset_n  input  1  asynchronous active-low reset
- sclk_posedge  input  1  one-cycle pulse per SCLK rising edge (conditioned)
- sclk_negedge  input  1  one-cycle pulse per SCLK falling edge (conditioned)
- cs_n  input  1  conditioned chip select, active low
- mosi  input  1  conditioned serial data in
- rx_data  output  WIDTH  last completed receive word
- rx_valid  output  1  rx_data holds an unacknowledged word
- rx_ack  input  1  consumer accepts rx_data
- tx_data  input  WIDTH  next transmit word
- tx_load  input  1  write tx_data into holding register
- tx_ready  output  1  holding register empty
- miso  output  1  serial data out
- miso_oe  output  1  MISO tri-state enable
- rx_overrun  output  1  present only with SPI_FRAME_OVERRUN_EN

## Operation
- FSM states: IDLE (cs_n=1), ACTIVE (cs_n=0). IDLE→ACTIVE on cs_n low; ACTIVE→IDLE on cs_n high from any bit count.
- Entering ACTIVE: bit counter = 0, rx shift cleared, tx shift loaded from holding register (all-ones if empty; holding becomes empty, tx_ready=1).
- ACTIVE, sclk_posedge: rx_shift = {rx_shift[WIDTH-2:0], mosi}; count++. On the WIDTH-th bit: rx_data ← completed word, rx_valid=1, count wraps to 0.
- ACTIVE, sclk_negedge: if count==0 (word boundary) reload tx shift from holding register (all-ones if empty); else shift left. miso = tx_shift MSB.
- tx_load while tx_ready=1: capture tx_data, tx_ready=0. tx_load while tx_ready=0: ignored, holding unchanged.
- rx_ack clears rx_valid. A new word completing in the same cycle as rx_ack: rx_valid stays 1 with the new word.
- cs_n high mid-word: partial word discarded, no rx_valid, count=0; holding register untouched.
- cs_n rising in same cycle as sclk_posedge/negedge: cs_n wins, edge ignored.
- miso_oe = registered ~cs_n; miso held at 0 in IDLE.

## Timing
- Reset values: rx_data=0, rx_valid=0, tx_ready=1, miso=0, miso_oe=0, rx_overrun=0, state IDLE, count 0.
- rx_valid/rx_data update the clk cycle after the cycle carrying the WIDTH-th sclk_posedge.
- miso updates the clk cycle after sclk_negedge; first bit (MSB) valid the cycle after cs_n falls.
- miso_oe follows cs_n with one cycle latency.
- tx_ready falls the cycle after an accepted tx_load; rises the cycle after the holding register transfers to the shifter.
- Edge pulses assumed ≥2 clk cycles apart; back-to-back pulses are still processed one per cycle.

## Configuration
- SPI_FRAME_OVERRUN_EN defined: rx_overrun port exists; set sticky when a word completes while rx_valid=1 and rx_ack=0 (new word still overwrites rx_data); cleared only by reset or by rx_ack.
- Undefined: no rx_overrun port; overwrite is silent.

## Structure
- Shared package: FSM state enum (IDLE, ACTIVE), WIDTH default constant, all-ones idle-fill constant.
- One natural sub-module: spi_bit_counter (count, wrap at WIDTH, word-boundary flag, clear on cs_n high).

## Test plan
- Reset asserted mid-word (after 3 bits) -> all outputs return to reset values, next frame of 0xA5 received correctly.
- cs_n low, 8 posedges with MOSI bits 1,0,1,0,0,1,0,1 -> rx_data=0xA5, rx_valid=1 one cycle after 8th pulse; rx_ack -> rx_valid=0.
- tx_load 0x3C before cs_n low, 8 negedges -> miso sequence 0,0,1,1,1,1,0,0; tx_ready 0 then 1 after transfer; second word with empty holding -> miso all ones.
- cs_n high after 5 posedges -> no rx_valid, next full frame 0x81 received as 0x81.
- Two frames 0x12, 0x34 without rx_ack -> rx_data=0x34, rx_valid=1, rx_overrun=1 (macro on) / no port (macro off).
- rx_ack coincident with 8th-bit completion -> rx_valid stays 1, rx_overrun stays 0.
